// File: rtl/rvh_mmu_ptw_arbiter.sv
// rvh_mmu_ptw_arbiter: shares one page-table walker among N_REQ TLB-miss MSHRs.
// Round-robin grant, ID = {req_idx, trans_id}, response routing by ID,
// outstanding-walk limit and an SFENCE drain sequencer (RUN -> DRAIN -> DONE).
// Optional MMU_PTW_ARB_OUT_REG_EN: one-entry output register toward the PTW.
module rvh_mmu_ptw_arbiter #(
  parameter int unsigned N_REQ        = 2,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned TRANS_ID_W   = 3,
  parameter int unsigned REQ_IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [N_REQ-1:0]                req_vld_i,
  input  logic [N_REQ*TRANS_ID_W-1:0]     req_trans_id_i,
  input  logic [N_REQ*16-1:0]             req_asid_i,
  input  logic [N_REQ*27-1:0]             req_vpn_i,
  input  logic [N_REQ*2-1:0]              req_access_type_i,
  output logic [N_REQ-1:0]                req_rdy_o,
  output logic                            ptw_req_vld_o,
  output logic [REQ_IDX_W+TRANS_ID_W-1:0] ptw_req_id_o,
  output logic [15:0]                     ptw_req_asid_o,
  output logic [26:0]                     ptw_req_vpn_o,
  output logic [1:0]                      ptw_req_access_type_o,
  input  logic                            ptw_req_rdy_i,
  input  logic                            ptw_resp_vld_i,
  input  logic [REQ_IDX_W+TRANS_ID_W-1:0] ptw_resp_id_i,
  output logic [N_REQ-1:0]                resp_vld_o,
  output logic [TRANS_ID_W-1:0]           resp_trans_id_o,
  input  logic                            flush_i,
  output logic                            flush_done_o,
  output logic                            busy_o
);

  localparam int unsigned ID_W  = REQ_IDX_W + TRANS_ID_W;
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [REQ_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     inflight_cnt_q, inflight_cnt_d;
  logic [1:0]           state_q, state_d;

  logic                 any_vld;
  logic [REQ_IDX_W-1:0] win_idx;
  int unsigned          arb_idx;
  logic [ID_W-1:0]      win_id;
  logic [15:0]          win_asid;
  logic [26:0]          win_vpn;
  logic [1:0]           win_at;
  logic                 can_issue;
  logic                 arb_fire;
  logic                 out_pending;
  logic [REQ_IDX_W-1:0] resp_idx;

  // Slot accounting uses the registered count only; a same-cycle response frees nothing.
  assign can_issue = (state_q == StRun) && (inflight_cnt_q < CNT_W'(MAX_INFLIGHT));

  // Round-robin search starting at rr_ptr, then mux the winner's payload.
  always_comb begin
    any_vld  = 1'b0;
    win_idx  = '0;
    arb_idx  = 0;
    win_id   = '0;
    win_asid = '0;
    win_vpn  = '0;
    win_at   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      arb_idx = (32'(rr_ptr_q) + k) % N_REQ;
      if (!any_vld && req_vld_i[arb_idx[REQ_IDX_W-1:0]]) begin
        any_vld = 1'b1;
        win_idx = arb_idx[REQ_IDX_W-1:0];
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (REQ_IDX_W'(i) == win_idx) begin
        win_id   = {win_idx, req_trans_id_i[i*TRANS_ID_W +: TRANS_ID_W]};
        win_asid = req_asid_i[i*16 +: 16];
        win_vpn  = req_vpn_i[i*27 +: 27];
        win_at   = req_access_type_i[i*2 +: 2];
      end
    end
  end

`ifdef MMU_PTW_ARB_OUT_REG_EN
  logic            out_vld_q, out_vld_d;
  logic [ID_W-1:0] out_id_q, out_id_d;
  logic [15:0]     out_asid_q, out_asid_d;
  logic [26:0]     out_vpn_q, out_vpn_d;
  logic [1:0]      out_at_q, out_at_d;

  // Arbitration may refill the register in the same cycle it drains to the PTW.
  assign arb_fire = any_vld && can_issue && (!out_vld_q || ptw_req_rdy_i);

  // Output register next state: load on arbitration fire, clear on PTW accept.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_id_d   = out_id_q;
    out_asid_d = out_asid_q;
    out_vpn_d  = out_vpn_q;
    out_at_d   = out_at_q;
    if (arb_fire) begin
      out_vld_d  = 1'b1;
      out_id_d   = win_id;
      out_asid_d = win_asid;
      out_vpn_d  = win_vpn;
      out_at_d   = win_at;
    end else if (out_vld_q && ptw_req_rdy_i) begin
      out_vld_d = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_vld_q  <= 1'b0;
      out_id_q   <= '0;
      out_asid_q <= '0;
      out_vpn_q  <= '0;
      out_at_q   <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_id_q   <= out_id_d;
      out_asid_q <= out_asid_d;
      out_vpn_q  <= out_vpn_d;
      out_at_q   <= out_at_d;
    end
  end

  assign ptw_req_vld_o         = out_vld_q;
  assign ptw_req_id_o          = out_id_q;
  assign ptw_req_asid_o        = out_asid_q;
  assign ptw_req_vpn_o         = out_vpn_q;
  assign ptw_req_access_type_o = out_at_q;
  assign out_pending           = out_vld_q;
`else
  assign ptw_req_vld_o         = any_vld && can_issue;
  assign arb_fire              = ptw_req_vld_o && ptw_req_rdy_i;
  assign ptw_req_id_o          = win_id;
  assign ptw_req_asid_o        = win_asid;
  assign ptw_req_vpn_o         = win_vpn;
  assign ptw_req_access_type_o = win_at;
  assign out_pending           = 1'b0;
`endif

  // One-hot ready to the granted requester.
  always_comb begin
    req_rdy_o = '0;
    if (arb_fire) req_rdy_o[win_idx] = 1'b1;
  end

  // Response routing by the echoed requester index; out-of-range indices match nothing.
  assign resp_idx        = ptw_resp_id_i[TRANS_ID_W +: REQ_IDX_W];
  assign resp_trans_id_o = ptw_resp_id_i[TRANS_ID_W-1:0];
  always_comb begin
    resp_vld_o = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      resp_vld_o[i] = ptw_resp_vld_i && (resp_idx == REQ_IDX_W'(i));
    end
  end

  // Pointer advance and in-flight count; a stray response at zero saturates.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (arb_fire) rr_ptr_d = REQ_IDX_W'((32'(win_idx) + 1) % N_REQ);
    inflight_cnt_d = inflight_cnt_q;
    if (arb_fire && !ptw_resp_vld_i) begin
      inflight_cnt_d = inflight_cnt_q + CNT_W'(1);
    end else if (!arb_fire && ptw_resp_vld_i && (inflight_cnt_q != '0)) begin
      inflight_cnt_d = inflight_cnt_q - CNT_W'(1);
    end
  end

  // Flush sequencer: stop granting, wait for all walks to retire, pulse done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:   if (flush_i) state_d = StDrain;
      StDrain: if ((inflight_cnt_q == '0) && !out_pending) state_d = StDone;
      StDone:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // Architectural state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr_q       <= '0;
      inflight_cnt_q <= '0;
      state_q        <= StRun;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      inflight_cnt_q <= inflight_cnt_d;
      state_q        <= state_d;
    end
  end

  assign flush_done_o = (state_q == StDone);
  assign busy_o       = (|req_vld_i) || (inflight_cnt_q != '0) || out_pending;

  // A response with nothing outstanding means the PTW and arbiter disagree.
  resp_at_zero_a: assert property (@(posedge clk) disable iff (!rstn)
    !(ptw_resp_vld_i && (inflight_cnt_q == '0)));

endmodule
